// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the sequential arithmetic units (multiplier, divider).
//   - Sequencer state encoding
//   - Iteration-counter width helper
package mult_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter must hold the value `width` itself, not just width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Handshake/operand bundle for shift_add_multiplier.
//   master: drives start, operands, signed_op; receives product, overflow, done, busy
//   slave : the multiplier side
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 signed_op;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;
  logic                 done;
  logic                 busy;

  modport master (
    output start, multiplicand, multiplier, signed_op,
    input  product, overflow, done, busy
  );

  modport slave (
    input  start, multiplicand, multiplier, signed_op,
    output product, overflow, done, busy
  );
endinterface

// File: rtl/shift_add_multiplier_magnitude_sign_unit.sv
// Conditional two's-complement negate.
//   value  : operand
//   negate : 1 returns -value, 0 returns value unchanged
//   result : WIDTH-bit result
module magnitude_sign_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);
  assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one partial product per clock.
// Signed operands are reduced to magnitudes, multiplied unsigned, then the
// sign is reapplied on the 2*WIDTH result.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of shift_add_multiplier_if (start/operands in,
//         product/overflow/done/busy out)
//
// state | meaning
// IDLE  | waiting for start; zero operand short-circuits to DONE
// CALC  | one add/shift step per cycle, WIDTH steps
// SIGN  | apply sign to accumulator, compute overflow
// DONE  | result held until start is seen low
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             signed_q, signed_d;
  logic [PW-1:0]    product_q, product_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    signed_prod;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   prod_top;
  logic             ovf;

  magnitude_sign_unit #(.WIDTH(WIDTH)) u_mag_a (
    .value  (bus.multiplicand),
    .negate (bus.signed_op & bus.multiplicand[WIDTH-1]),
    .result (a_mag)
  );

  magnitude_sign_unit #(.WIDTH(WIDTH)) u_mag_b (
    .value  (bus.multiplier),
    .negate (bus.signed_op & bus.multiplier[WIDTH-1]),
    .result (b_mag)
  );

  magnitude_sign_unit #(.WIDTH(PW)) u_sign_fix (
    .value  (acc_q),
    .negate (neg_q),
    .result (signed_prod)
  );

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    // Carry out of the upper half lands in the top bit after the shift.
    sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
    prod_top = signed_prod[PW-1:WIDTH-1];
    ovf      = signed_q ? !((&prod_top) || !(|prod_top))
                        : (|signed_prod[PW-1:WIDTH]);

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    signed_d   = signed_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.multiplicand == '0 || bus.multiplier == '0) begin
            product_d  = '0;
            overflow_d = 1'b0;
            state_d    = DONE;
          end else begin
            mcand_d  = a_mag;
            mplier_d = b_mag;
            neg_d    = bus.signed_op & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
            signed_d = bus.signed_op;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        product_d  = signed_prod;
        overflow_d = ovf;
        state_d    = DONE;
      end
      DONE: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      signed_q   <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      signed_q   <= signed_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q == CALC) || (state_q == SIGN);
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  shift_add_multiplier_if #(.WIDTH(W)) bus_if ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply on the interpreted operand values.
  function automatic longint ref_value(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return pa * pb;
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint p;
    p = ref_value(a, b, s);
    return p[2*W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint p;
    p = ref_value(a, b, s);
    if (s) return (p < -(longint'(1) << (W-1))) || (p > ((longint'(1) << (W-1)) - 1));
    return p > ((longint'(1) << W) - 1);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold, input bit scramble, input string tag);
    logic [2*W-1:0] exp_p;
    logic           exp_o;
    int             exp_lat, e, busy_cnt;
    bit             seen;
    exp_p   = ref_prod(a, b, s);
    exp_o   = ref_ovf(a, b, s);
    exp_lat = (a == '0 || b == '0) ? 0 : W + 1;

    @(negedge clk);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = a;
    bus_if.multiplier   = b;
    bus_if.signed_op    = s;
    @(posedge clk);  // edge 0
    e = 0; busy_cnt = 0; seen = 0;
    while (e < 40) begin
      @(negedge clk);
      if (scramble && e == 3) begin
        bus_if.multiplicand = W'($urandom_range(0, 255));
        bus_if.multiplier   = W'($urandom_range(0, 255));
        bus_if.signed_op    = ~s;
      end
      if (bus_if.done) begin
        seen = 1;
        break;
      end
      if (bus_if.busy) busy_cnt++;
      @(posedge clk);
      e++;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(e), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, " product"}, 32'(bus_if.product), 32'(exp_p));
    chk({tag, " overflow"}, 32'(bus_if.overflow), 32'(exp_o));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold_done"}, 32'(bus_if.done), 32'd1);
      chk({tag, " hold_busy"}, 32'(bus_if.busy), 32'd0);
      chk({tag, " hold_product"}, 32'(bus_if.product), 32'(exp_p));
    end

    @(negedge clk);
    bus_if.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_fall"}, 32'(bus_if.done), 32'd0);
    chk({tag, " idle_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    rst                 = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.multiplicand = '0;
    bus_if.multiplier   = '0;
    bus_if.signed_op    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset product", 32'(bus_if.product), 32'd0);
    chk("reset overflow", 32'(bus_if.overflow), 32'd0);
    chk("reset done", 32'(bus_if.done), 32'd0);
    chk("reset busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle done", 32'(bus_if.done), 32'd0);

    do_op(8'd200, 8'd3,   1'b0, 0, 0, "u200x3");
    do_op(8'd15,  8'd17,  1'b0, 0, 0, "u15x17");
    do_op(8'd255, 8'd255, 1'b0, 0, 0, "u255x255");
    do_op(8'h9C,  8'd10,  1'b1, 0, 0, "s-100x10");
    do_op(8'd100, 8'hFF,  1'b1, 0, 0, "s100x-1");
    do_op(8'h80,  8'h80,  1'b1, 0, 0, "s-128x-128");
    do_op(8'hF4,  8'hF6,  1'b1, 0, 0, "s-12x-10");
    do_op(8'h80,  8'd1,   1'b1, 0, 0, "s-128x1");
    do_op(8'd0,   8'd255, 1'b0, 0, 0, "u0x255");
    do_op(8'hFB,  8'd0,   1'b1, 0, 0, "s-5x0");
    do_op(8'd15,  8'd17,  1'b0, 5, 0, "held_start");
    do_op(8'd0,   8'd9,   1'b0, 3, 0, "held_start_zero");
    do_op(8'd200, 8'd3,   1'b0, 0, 1, "scramble_u");
    do_op(8'hF4,  8'd77,  1'b1, 0, 1, "scramble_s");

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      do_op(ra, rb, rs, 0, 0, $sformatf("rand%0d", i));
    end

    // Abort mid-CALC: reset asserted during the 4th CALC cycle.
    @(negedge clk);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = 8'd50;
    bus_if.multiplier   = 8'd3;
    bus_if.signed_op    = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_abort busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort product", 32'(bus_if.product), 32'd0);
    chk("abort overflow", 32'(bus_if.overflow), 32'd0);
    chk("abort done", 32'(bus_if.done), 32'd0);
    chk("abort busy", 32'(bus_if.busy), 32'd0);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort done", 32'(bus_if.done), 32'd0);
    do_op(8'd7, 8'd6, 1'b0, 0, 0, "u7x6_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential signed/unsigned shift-add multiplier, the multiplicative counterpart of the non-restoring divider in the arithmetic-logical-units group. It computes a full 2*width product one partial-product step per clock. It shares the divider's start/done/busy handshake and signed_op convention, so both units can sit behind the same ALU sequencer. It reports whether the product fits back into width bits.

## Interface
- width, default 8: operand width in bits, must be 2 or more; product is 2*width bits.
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous and active-low.
- start, input, 1: request; sampled only in IDLE.
- multiplicand, input, width: operand A, two's complement when signed_op=1.
- multiplier, input, width: operand B, two's complement when signed_op=1.
- signed_op, input, 1: 1 selects signed multiply, 0 selects unsigned; sampled with start.
- product, output, 2*width: result, valid while done=1.
- overflow, output, 1: result does not fit in width bits; valid while done=1.
- done, output, 1: result valid.
- busy, output, 1: computation in progress.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start=1, both operands nonzero:
  - capture the magnitudes |A| and |B|; in signed mode negate negative operands, in unsigned mode take them as-is;
  - capture neg = signed_op & (A[msb] ^ B[msb]) and signed_op;
  - clear the accumulator; set the iteration counter to width; go to CALC.
- IDLE, start=1, either operand zero:
  - load product=0 and overflow=0; go directly to DONE (early-out).
- CALC, once per cycle:
  - if the multiplier-magnitude LSB is 1, add the multiplicand magnitude to the accumulator's upper half;
  - shift the accumulator and the multiplier register right one bit;
  - decrement the counter; when it reaches 0, go to SIGN.
- Arithmetic width:
  - the magnitudes are width-bit unsigned; the most-negative operand (-2^(width-1)) is still representable as a magnitude;
  - the adder is width+1 bits and its carry shifts into the accumulator.
- SIGN:
  - product = neg ? two's-complement of the accumulator : accumulator;
  - overflow: unsigned mode, product[2w-1:w] != 0; signed mode, product[2w-1:w-1] is not all zeros and not all ones;
  - go to DONE.
- DONE:
  - hold done=1 with product and overflow stable;
  - return to IDLE when start=0. A start held high does not retrigger; a new operation requires start low, then high.
- start in CALC or SIGN is ignored; operand or signed_op changes after capture have no effect.
- No divide-by-zero analogue exists, so there is no error output.

## Timing
- Reset, asynchronous on rst falling: state=IDLE; product=0, overflow=0, done=0, busy=0; accumulator and counter cleared. This applies in any state, including mid-CALC, and aborts the operation.
- Edge numbering: edge 0 is the edge that samples start=1 in IDLE.
- busy=1 from after edge 0 through edge width+1 (covers CALC and SIGN); busy=0 in IDLE and DONE.
- Normal latency: done=1 after edge width+1, so width+1 cycles. For width=8, done rises after the 9th edge.
- Early-out latency: done=1 after edge 0, 1 cycle; busy stays 0.
- done, product and overflow are registered outputs; no combinational path from the inputs.
- DONE to IDLE: done falls on the first edge that samples start=0.

## Structure
- Shared package mult_pkg holds:
  - the state encoding localparams (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3);
  - a function for the counter width, clog2(width+1).
- The divider should take its state and counter constants from the same package style.
- One natural sub-module, magnitude_sign_unit: a combinational conditional two's-complement negate, parameterized on bit width.
  - Instantiated twice at width bits for operand magnitudes.
  - Instantiated once at 2*width bits for the final sign fix.
- The FSM, counter and accumulator datapath stay in shift_add_multiplier.

## Test plan
All scenarios use width=8.
- Unsigned 200*3 -> product=16'h0258 (600), overflow=1; done after 9 cycles; busy high for 9 cycles.
- Unsigned 15*17 -> product=255, overflow=0; unsigned 255*255 -> product=16'hFE01, overflow=1.
- Signed -100*10 -> product=16'hFC18 (-1000), overflow=1; signed 100*-1 -> 16'hFF9C, overflow=0.
- Signed -128*-128 -> 16'h4000, overflow=1; signed -12*-10 -> 120, overflow=0; signed -128*1 -> 16'hFF80, overflow=0.
- Zero early-out: 0*255 unsigned and -5*0 signed -> product=0, overflow=0, done after 1 cycle, busy never high.
- Handshake and reset:
  - start held high through DONE -> exactly one operation;
  - operand changes during CALC ignored;
  - rst pulled low on the 4th CALC cycle -> all outputs 0 immediately, IDLE; a next 7*6 -> 42.
